// File: rtl/id_branch_pred_pkg.sv
// id_branch_pred_pkg: branch op encodings and 2-bit counter states shared by the ID branch logic.
package id_branch_pred_pkg;
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  function automatic logic is_branch(input logic [2:0] op);
    return op >= BR_BEQ && op <= BR_BGEZ;
  endfunction
endpackage

// File: rtl/id_branch_pred_cmp.sv
// branch_cmp: combinational MIPS branch condition evaluator, signed single-operand compares.
module branch_cmp
  import id_branch_pred_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] id_a,
  input  logic [DW-1:0] id_b,
  input  logic [2:0]    id_br_op,
  output logic          taken
);
  logic neg, zero;
  assign neg  = id_a[DW-1];
  assign zero = id_a == '0;
  assign taken = id_br_op == BR_BEQ  ? id_a == id_b :
                 id_br_op == BR_BNE  ? id_a != id_b :
                 id_br_op == BR_BLEZ ? neg || zero :
                 id_br_op == BR_BGTZ ? !neg && !zero :
                 id_br_op == BR_BLTZ ? neg :
                 id_br_op == BR_BGEZ ? !neg : 1'b0;
endmodule

// File: rtl/id_branch_pred.sv
// id_branch_pred: ID-stage branch resolution with direct-mapped BTB prediction,
// mispredict redirect and saturating statistics.
module id_branch_pred
  import id_branch_pred_pkg::*;
#(
  parameter int DW    = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    if_pc,
  output logic             if_pred_taken,
  output logic [DW-1:0]    if_pred_target,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [DW-1:0]    id_pc,
  input  logic [2:0]       id_br_op,
  input  logic [DW-1:0]    id_a,
  input  logic [DW-1:0]    id_b,
  input  logic [DW-1:0]    id_target,
  input  logic             id_pred_taken,
  input  logic [DW-1:0]    id_pred_target,
  output logic             Branch,
  output logic             redirect,
  output logic [DW-1:0]    redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int N = 1 << IDX_W;
  logic [N-1:0]     valid_q;
  logic [1:0]       ctr_q [N];
  logic [TAG_W-1:0] tag_q [N];
  logic [DW-1:0]    tgt_q [N];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic [1:0]       ctr_d;
  logic             cmp_taken, is_br, act, mispredict, u_hit, upd, inval;
  logic             unused_bits;
  assign unused_bits = ^{if_pc[DW-1:IDX_W+TAG_W+2], if_pc[1:0]};
  assign f_idx = if_pc[IDX_W+1:2];
  assign f_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = id_pc[IDX_W+1:2];
  assign u_tag = id_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_pred_taken  = valid_q[f_idx] && tag_q[f_idx] == f_tag && ctr_q[f_idx][1];
  assign if_pred_target = if_pred_taken ? tgt_q[f_idx] : '0;
  branch_cmp #(.DW(DW)) u_cmp (
    .id_a    (id_a),
    .id_b    (id_b),
    .id_br_op(id_br_op),
    .taken   (cmp_taken)
  );
  always_comb begin
    is_br      = is_branch(id_br_op);
    act        = id_valid && !id_stall;
    Branch     = id_valid && cmp_taken;
    mispredict = (Branch != id_pred_taken) || (Branch && id_pred_taken && id_pred_target != id_target);
    // Any non-branch predicted taken is a BTB alias: fall through and drop the entry.
    redirect    = act && (is_br ? mispredict : id_pred_taken);
    redirect_pc = (redirect && Branch) ? id_target : id_pc + DW'(4);
    upd         = act && is_br;
    inval       = act && !is_br && id_pred_taken;
    u_hit       = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    ctr_d = !Branch ? (ctr_q[u_idx] == CTR_SNT ? CTR_SNT : ctr_q[u_idx] - 2'd1) :
            !u_hit ? CTR_WT :
            ctr_q[u_idx] == CTR_ST ? CTR_ST : ctr_q[u_idx] + 2'd1;
    br_cnt_d  = (upd && br_cnt_q != '1) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    mis_cnt_d = (redirect && mis_cnt_q != '1) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= CTR_WNT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (upd && (Branch || u_hit)) ctr_q[u_idx] <= ctr_d;
      if (upd && Branch) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= id_target;
      end
      if (inval) valid_q[u_idx] <= 1'b0;
    end
  end
  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;
endmodule

// File: tb/tb_id_branch_pred.sv
// tb_id_branch_pred: directed comparator table plus BTB, stall, reset, alias and saturation sequences.
module tb_id_branch_pred;
  import id_branch_pred_pkg::*;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] if_pc = 0, id_pc = 0, id_a = 0, id_b = 0, id_target = 0, id_pred_target = 0;
  logic        id_valid = 0, id_stall = 0, id_pred_taken = 0;
  logic [2:0]  id_br_op = BR_NONE;
  logic        if_pred_taken, Branch, redirect;
  logic [31:0] if_pred_target, redirect_pc;
  logic [15:0] br_cnt, mispred_cnt;
  int          passed = 0, total = 0;

  id_branch_pred dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .id_valid(id_valid), .id_stall(id_stall),
    .id_pc(id_pc), .id_br_op(id_br_op), .id_a(id_a), .id_b(id_b), .id_target(id_target),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target), .Branch(Branch),
    .redirect(redirect), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    id_valid = v; id_br_op = op; id_pc = pc; id_a = a; id_b = b;
    id_target = tgt; id_pred_taken = pt; id_pred_target = ptgt;
  endtask

  initial begin
    vecs[0]  = '{1, BR_BEQ,  32'd5,        32'd5,        1};
    vecs[1]  = '{1, BR_BEQ,  32'd5,        32'd6,        0};
    vecs[2]  = '{1, BR_BNE,  32'd5,        32'd6,        1};
    vecs[3]  = '{1, BR_BNE,  32'd7,        32'd7,        0};
    vecs[4]  = '{1, BR_BLTZ, 32'h80000000, 32'd0,        1};
    vecs[5]  = '{1, BR_BGEZ, 32'h80000000, 32'd0,        0};
    vecs[6]  = '{1, BR_BLEZ, 32'h80000000, 32'd0,        1};
    vecs[7]  = '{1, BR_BGTZ, 32'h80000000, 32'd0,        0};
    vecs[8]  = '{1, BR_BLEZ, 32'd0,        32'd9,        1};
    vecs[9]  = '{1, BR_BGEZ, 32'd0,        32'd9,        1};
    vecs[10] = '{1, BR_BGTZ, 32'd0,        32'd9,        0};
    vecs[11] = '{1, BR_BLTZ, 32'd0,        32'd9,        0};
    vecs[12] = '{1, BR_BGTZ, 32'd1,        32'hffffffff, 1};
    vecs[13] = '{1, BR_NONE, 32'd5,        32'd5,        0};
    vecs[14] = '{1, 3'd7,    32'd5,        32'd5,        0};
    vecs[15] = '{0, BR_BEQ,  32'd5,        32'd5,        0};

    repeat (2) step();
    rst = 0;
    if_pc = 32'h00400010;
    #1;
    chk("rst_pred_taken", {31'b0, if_pred_taken}, 0);
    chk("rst_pred_target", if_pred_target, 0);
    chk("rst_br_cnt", {16'b0, br_cnt}, 0);
    chk("rst_mispred_cnt", {16'b0, mispred_cnt}, 0);

    // Comparator table under stall: no state change, no redirect.
    id_stall = 1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].op, 32'h00400200, vecs[i].a, vecs[i].b, 32'h00400300, 0, 0);
      #1;
      chk($sformatf("tbl%0d_branch", i), {31'b0, Branch}, {31'b0, vecs[i].exp});
      chk($sformatf("tbl%0d_redirect", i), {31'b0, redirect}, 0);
    end
    chk("tbl_redirect_pc", redirect_pc, 32'h00400204);
    chk("tbl_br_cnt", {16'b0, br_cnt}, 0);
    id_stall = 0;

    // First taken BEQ allocates with ctr=2.
    drive(1, BR_BEQ, 32'h00400010, 5, 5, 32'h00400040, 0, 0);
    #1;
    chk("beq1_branch", {31'b0, Branch}, 1);
    chk("beq1_redirect", {31'b0, redirect}, 1);
    chk("beq1_redirect_pc", redirect_pc, 32'h00400040);
    chk("beq1_same_idx_lookup", {31'b0, if_pred_taken}, 0);
    step();
    id_valid = 0;
    #1;
    chk("beq1_pred_taken", {31'b0, if_pred_taken}, 1);
    chk("beq1_pred_target", if_pred_target, 32'h00400040);
    chk("beq1_br_cnt", {16'b0, br_cnt}, 1);
    chk("beq1_mispred_cnt", {16'b0, mispred_cnt}, 1);

    // Correctly predicted taken: ctr -> 3, no redirect.
    drive(1, BR_BEQ, 32'h00400010, 5, 5, 32'h00400040, 1, 32'h00400040);
    #1;
    chk("beq2_redirect", {31'b0, redirect}, 0);
    chk("beq2_redirect_pc", redirect_pc, 32'h00400014);
    step();
    // Not taken: ctr 3 -> 2, still predicts taken.
    drive(1, BR_BEQ, 32'h00400010, 5, 6, 32'h00400040, 1, 32'h00400040);
    #1;
    chk("beq3_branch", {31'b0, Branch}, 0);
    chk("beq3_redirect", {31'b0, redirect}, 1);
    chk("beq3_redirect_pc", redirect_pc, 32'h00400014);
    step();
    id_valid = 0;
    #1;
    chk("beq3_pred_taken", {31'b0, if_pred_taken}, 1);
    chk("beq3_mispred_cnt", {16'b0, mispred_cnt}, 2);
    id_valid = 1;
    step();
    id_valid = 0;
    #1;
    chk("beq4_pred_taken", {31'b0, if_pred_taken}, 0);
    chk("beq4_pred_target", if_pred_target, 0);
    chk("beq4_br_cnt", {16'b0, br_cnt}, 4);
    chk("beq4_mispred_cnt", {16'b0, mispred_cnt}, 3);

    // Stalled taken BNE: nothing happens until release, then one update.
    if_pc = 32'h00400020;
    drive(1, BR_BNE, 32'h00400020, 1, 2, 32'h00400080, 0, 0);
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_redirect", i), {31'b0, redirect}, 0);
      chk($sformatf("stall%0d_br_cnt", i), {16'b0, br_cnt}, 4);
      step();
    end
    chk("stall_no_alloc", {31'b0, if_pred_taken}, 0);
    id_stall = 0;
    #1;
    chk("stall_release_redirect", {31'b0, redirect}, 1);
    step();
    id_valid = 0;
    #1;
    chk("stall_br_cnt", {16'b0, br_cnt}, 5);
    chk("stall_mispred_cnt", {16'b0, mispred_cnt}, 4);
    chk("stall_pred_taken", {31'b0, if_pred_taken}, 1);
    chk("stall_pred_target", if_pred_target, 32'h00400080);

    // Branch coinciding with reset is discarded.
    if_pc = 32'h00400030;
    drive(1, BR_BEQ, 32'h00400030, 3, 3, 32'h004000c0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    id_valid = 0;
    #1;
    chk("rstupd_pred_taken", {31'b0, if_pred_taken}, 0);
    chk("rstupd_br_cnt", {16'b0, br_cnt}, 0);
    chk("rstupd_mispred_cnt", {16'b0, mispred_cnt}, 0);

    // Alias: allocate at 0x00400100, then a predicted-taken non-branch invalidates it.
    if_pc = 32'h00400100;
    drive(1, BR_BEQ, 32'h00400100, 0, 0, 32'h00400200, 0, 0);
    step();
    id_valid = 0;
    #1;
    chk("alias_alloc", {31'b0, if_pred_taken}, 1);
    drive(1, BR_NONE, 32'h00400100, 0, 0, 32'h00400200, 1, 32'h00400200);
    #1;
    chk("alias_branch", {31'b0, Branch}, 0);
    chk("alias_redirect", {31'b0, redirect}, 1);
    chk("alias_redirect_pc", redirect_pc, 32'h00400104);
    step();
    id_valid = 0;
    #1;
    chk("alias_invalidated", {31'b0, if_pred_taken}, 0);
    chk("alias_br_cnt", {16'b0, br_cnt}, 1);
    chk("alias_mispred_cnt", {16'b0, mispred_cnt}, 2);

    // Mispredict counter saturation: 2^16 + 3 redirects from reset.
    rst = 1;
    step();
    rst = 0;
    drive(1, BR_NONE, 32'h00400100, 0, 0, 0, 1, 0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", {16'b0, mispred_cnt}, 32'h0000fffe);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_mispred_cnt", {16'b0, mispred_cnt}, 32'h0000ffff);
    chk("sat_br_cnt", {16'b0, br_cnt}, 0);
    id_valid = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
